// File: rtl/disp_msg_sched.sv
// ============================================================================
// Module  : disp_msg_sched
// Brief   : Round-robin scheduler sharing one UART TX byte path between four
//           7-byte message requesters; appends a CR terminator per message.
//           Optional macro DISP_MSG_SCHED_LF_EN appends a line feed after CR.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_msg_sched #(
  parameter int          NBYTES = 7,
  parameter logic [7:0]  TERM   = 8'h0d
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [8*NBYTES-1:0]   msg0,
  input  logic [8*NBYTES-1:0]   msg1,
  input  logic [8*NBYTES-1:0]   msg2,
  input  logic [8*NBYTES-1:0]   msg3,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  output logic [3:0]            gnt,
  output logic [3:0]            done,
  output logic                  busy
);

  localparam int IW = $clog2(NBYTES + 1);

`ifdef DISP_MSG_SCHED_LF_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SEND = 3'd1, S_TERM = 3'd2, S_LF = 3'd3, S_DONE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SEND = 3'd1, S_TERM = 3'd2, S_DONE = 3'd4
  } state_t;
`endif

  state_t                state_q;
  logic [8*NBYTES-1:0]   buf_q;
  logic [IW-1:0]         idx_q;
  logic [1:0]            ptr_q;
  logic [1:0]            win_q;
  logic                  tx_valid_q;
  logic [7:0]            tx_data_q;
  logic [3:0]            gnt_q;
  logic [3:0]            done_q;

  logic [1:0]            win_d;
  logic [8*NBYTES-1:0]   msg_d;

  // Scan downward so the requester closest to the pointer overwrites last.
  always_comb begin
    win_d = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) win_d = ptr_q + 2'(i);
    end
  end

  always_comb begin
    msg_d = msg0;
    case (win_d)
      2'd0:    msg_d = msg0;
      2'd1:    msg_d = msg1;
      2'd2:    msg_d = msg2;
      default: msg_d = msg3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      idx_q      <= '0;
      ptr_q      <= 2'd0;
      win_q      <= 2'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      gnt_q      <= 4'b0000;
      done_q     <= 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 4'b0000;
          if (req != 4'b0000) begin
            win_q      <= win_d;
            gnt_q      <= 4'b0001 << win_d;
            buf_q      <= msg_d;
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= msg_d[7:0];
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          // buf_q shifts so the byte after the one on tx_data sits at [15:8]
          if (tx_ready) begin
            if (idx_q == IW'(NBYTES - 1)) begin
              tx_data_q <= TERM;
              state_q   <= S_TERM;
            end else begin
              idx_q     <= idx_q + IW'(1);
              tx_data_q <= buf_q[15:8];
              buf_q     <= buf_q >> 8;
            end
          end
        end
`ifdef DISP_MSG_SCHED_LF_EN
        S_TERM: begin
          if (tx_ready) begin
            tx_data_q <= 8'h0a;
            state_q   <= S_LF;
          end
        end
        S_LF: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            gnt_q      <= 4'b0000;
            done_q     <= 4'b0001 << win_q;
            ptr_q      <= win_q + 2'd1;
            state_q    <= S_DONE;
          end
        end
`else
        S_TERM: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            gnt_q      <= 4'b0000;
            done_q     <= 4'b0001 << win_q;
            ptr_q      <= win_q + 2'd1;
            state_q    <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          done_q  <= 4'b0000;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = |gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_msg_sched.sv
// ============================================================================
// Module  : tb_disp_msg_sched
// Brief   : Directed self-checking bench for disp_msg_sched (CR, optional LF).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_msg_sched;

  localparam int NB = 7;
`ifdef DISP_MSG_SCHED_LF_EN
  localparam int XLEN = NB + 2;
`else
  localparam int XLEN = NB + 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [8*NB-1:0] msg0, msg1, msg2, msg3;
  logic          tx_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic [3:0]    gnt;
  logic [3:0]    done;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] cap_bytes [0:15];
  int         cap_n;
  int         cap_cyc;
  logic [3:0] cap_done;
  logic [3:0] cap_gnt;
  logic [3:0] cap_gnt_done;
  logic       cap_valid_done;
  bit         cap_stable;
  bit         cap_to;

  disp_msg_sched #(.NBYTES(NB), .TERM(8'h0d)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .msg0     (msg0),
    .msg1     (msg1),
    .msg2     (msg2),
    .msg3     (msg3),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_byte(input logic [8*NB-1:0] m, input int k);
    if (k < NB)       return m[8*k +: 8];
    else if (k == NB) return 8'h0d;
    else              return 8'h0a;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives tx_ready from a pattern and records accepted bytes until done pulses.
  task automatic xfer(input int maxc, input logic [31:0] rpat);
    logic       held;
    logic [7:0] hd;
    cap_n = 0; cap_cyc = -1; cap_done = 4'b0; cap_gnt = 4'b0; cap_gnt_done = 4'bx;
    cap_valid_done = 1'bx; cap_stable = 1'b1; cap_to = 1'b1;
    for (int k = 0; k < 16; k++) cap_bytes[k] = 8'h00;
    for (int c = 0; c < maxc; c++) begin
      tx_ready = rpat[c % 32];
      if (gnt != 4'b0 && cap_gnt == 4'b0) cap_gnt = gnt;
      if (tx_valid && tx_ready && cap_n < 16) begin
        cap_bytes[cap_n] = tx_data;
        cap_n++;
      end
      held = tx_valid && !tx_ready;
      hd   = tx_data;
      tick();
      if (held && (!tx_valid || tx_data !== hd)) cap_stable = 1'b0;
      if (done != 4'b0) begin
        cap_done = done; cap_cyc = c; cap_gnt_done = gnt;
        cap_valid_done = tx_valid; cap_to = 1'b0;
        break;
      end
    end
    tx_ready = 1'b1;
    if (cap_to) begin
      errors++; checks++;
      $display("FAIL xfer_timeout: no done pulse within %0d cycles", maxc);
    end
  endtask

  task automatic check_bytes(input string name, input logic [8*NB-1:0] m);
    checks++;
    if (cap_n !== XLEN) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes, expected %0d", name, cap_n, XLEN);
    end
    for (int k = 0; k < XLEN; k++) begin
      checks++;
      if (cap_bytes[k] !== exp_byte(m, k)) begin
        errors++;
        $display("FAIL %s_byte%0d: got %h expected %h", name, k, cap_bytes[k], exp_byte(m, k));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0; tx_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks += 5;
    if (tx_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", tx_valid); end
    if (tx_data !== 8'h00)   begin errors++; $display("FAIL reset_data: got %h expected 00", tx_data); end
    if (gnt !== 4'b0000)     begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    if (done !== 4'b0000)    begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    req = 4'b0001;
    xfer(40, 32'hFFFF_FFFF);
    req = 4'b0000;
    check_bytes("single", msg0);
    checks += 6;
    if (cap_gnt !== 4'b0001)     begin errors++; $display("FAIL single_gnt: got %b expected 0001", cap_gnt); end
    if (cap_done !== 4'b0001)    begin errors++; $display("FAIL single_done: got %b expected 0001", cap_done); end
    if (cap_cyc !== XLEN)        begin errors++; $display("FAIL single_latency: got %0d expected %0d", cap_cyc, XLEN); end
    if (cap_gnt_done !== 4'b0)   begin errors++; $display("FAIL single_gnt_at_done: got %b expected 0000", cap_gnt_done); end
    if (cap_valid_done !== 1'b0) begin errors++; $display("FAIL single_valid_at_done: got %b expected 0", cap_valid_done); end
    tick();
    if (done !== 4'b0000)        begin errors++; $display("FAIL single_done_width: got %b expected 0000", done); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_d [0:2];
    exp_d[0] = 4'b0010; exp_d[1] = 4'b1000; exp_d[2] = 4'b0010;
    req = 4'b1010;
    for (int t = 0; t < 3; t++) begin
      xfer(40, 32'hFFFF_FFFF);
      if (t == 2) req = 4'b0000;
      check_bytes($sformatf("cont%0d", t), (exp_d[t] == 4'b0010) ? msg1 : msg3);
      checks += 3;
      if (cap_done !== exp_d[t]) begin errors++; $display("FAIL cont%0d_done: got %b expected %b", t, cap_done, exp_d[t]); end
      if (cap_gnt !== exp_d[t])  begin errors++; $display("FAIL cont%0d_gnt: got %b expected %b", t, cap_gnt, exp_d[t]); end
      if (cap_cyc !== ((t == 0) ? XLEN : XLEN + 1)) begin
        errors++;
        $display("FAIL cont%0d_latency: got %0d expected %0d", t, cap_cyc, (t == 0) ? XLEN : XLEN + 1);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    req = 4'b0001;
    xfer(120, 32'h9999_9999);
    req = 4'b0000;
    check_bytes("bp", msg0);
    checks += 2;
    if (cap_stable !== 1'b1)  begin errors++; $display("FAIL bp_stable: got %b expected 1", cap_stable); end
    if (cap_done !== 4'b0001) begin errors++; $display("FAIL bp_done: got %b expected 0001", cap_done); end
    tick();
  endtask

  task automatic test_msg_change();
    logic [8*NB-1:0] orig;
    orig = msg2;
    req = 4'b0100;
    tick();
    checks += 2;
    if (gnt !== 4'b0100)      begin errors++; $display("FAIL mc_gnt: got %b expected 0100", gnt); end
    if (tx_data !== orig[7:0]) begin errors++; $display("FAIL mc_first: got %h expected %h", tx_data, orig[7:0]); end
    msg2 = 56'hFF_EE_DD_CC_BB_AA_99;
    tick();
    req = 4'b0000;
    // First byte already accepted at the edge above with tx_ready high.
    xfer(40, 32'hFFFF_FFFF);
    checks += 2;
    if (cap_n !== XLEN - 1) begin errors++; $display("FAIL mc_count: got %0d expected %0d", cap_n, XLEN - 1); end
    for (int k = 1; k < XLEN; k++) begin
      checks++;
      if (cap_bytes[k-1] !== exp_byte(orig, k)) begin
        errors++;
        $display("FAIL mc_byte%0d: got %h expected %h", k, cap_bytes[k-1], exp_byte(orig, k));
      end
    end
    if (cap_done !== 4'b0100) begin errors++; $display("FAIL mc_done: got %b expected 0100", cap_done); end
    tick();
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    req = 4'b0010; tx_ready = 1'b1;
    for (int c = 0; c < 20 && acc < 3; c++) begin
      if (tx_valid && tx_ready) acc++;
      tick();
    end
    checks += 2;
    if (acc !== 3)        begin errors++; $display("FAIL rm_progress: got %0d bytes expected 3", acc); end
    if (gnt !== 4'b0010)  begin errors++; $display("FAIL rm_gnt: got %b expected 0010", gnt); end
    rst = 1'b1; req = 4'b0000;
    tick();
    rst = 1'b0;
    checks += 4;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", tx_valid); end
    if (gnt !== 4'b0000)   begin errors++; $display("FAIL rm_gnt_clr: got %b expected 0000", gnt); end
    if (done !== 4'b0000)  begin errors++; $display("FAIL rm_done: got %b expected 0000", done); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
    req = 4'b1111;
    xfer(40, 32'hFFFF_FFFF);
    req = 4'b0000;
    checks += 2;
    if (cap_gnt !== 4'b0001)  begin errors++; $display("FAIL rm_regrant: got %b expected 0001", cap_gnt); end
    if (cap_done !== 4'b0001) begin errors++; $display("FAIL rm_redone: got %b expected 0001", cap_done); end
    tick();
  endtask

  initial begin
    for (int k = 0; k < NB; k++) begin
      msg0[8*k +: 8] = 8'h41 + 8'(k);
      msg1[8*k +: 8] = 8'h11 + 8'(k);
      msg2[8*k +: 8] = 8'hA0 + 8'(k);
      msg3[8*k +: 8] = 8'h31 + 8'(k);
    end
    test_reset();
    test_single();
    test_contention();
    msg0 = 56'h6D_6C_6B_6A_69_68_67;
    test_backpressure();
    test_msg_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/disp_msg_sched.md
Name: disp_msg_sched

Overview:
- Round-robin scheduler that shares the single serial text output path (UART transmit byte interface) between four message requesters, e.g. clock display, alarm and status reporters.
- Each requester presents a 7-byte message and holds a request.
- The block grants one requester, latches its message and sequences the bytes out one per handshake, then appends a carriage-return terminator.
- It then signals completion and rotates priority.

Parameters:
- NBYTES, 7: message bytes per request; message bus width = 8*NBYTES.
- TERM, 8'h0d: terminator byte sent after the last message byte.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req  input  4  request level per requester; held until the matching done pulse
- msg0  input  8*NBYTES  requester 0 message; byte k = msg0[8k+7:8k]; byte 0 is sent first
- msg1  input  8*NBYTES  requester 1 message
- msg2  input  8*NBYTES  requester 2 message
- msg3  input  8*NBYTES  requester 3 message
- tx_ready  input  1  downstream transmitter can accept a byte this cycle
- tx_valid  output  1  tx_data holds a valid byte
- tx_data  output  8  byte to transmit
- gnt  output  4  one-hot grant, high for the whole transfer
- done  output  4  one-cycle pulse to the granted requester after its terminator is accepted
- busy  output  1  high while a transfer is in progress (gnt != 0)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: tx_valid=0, tx_data=8'h00, gnt=4'b0000, done=4'b0000, busy=0, state=IDLE, byte index=0, round-robin pointer=0 (requester 0 has highest priority).
- Reset wins over every other event. A reset mid-transfer drops tx_valid and gnt at the next edge and issues no done pulse.
- Transfer rule: a byte transfers on a posedge where tx_valid && tx_ready. tx_data and tx_valid are stable until accepted.
- States:
  - IDLE: if req!=0, pick the first set bit searching upward (with wrap) from the pointer. On the next edge: gnt=onehot(winner), latch the winner's msg into an internal buffer, index=0, tx_valid=1, tx_data=byte0, go to SEND. With req==0, stay in IDLE.
  - SEND: on an accepted byte, index++. The next byte is presented in the following cycle with no bubble, so tx_valid stays high. After byte NBYTES-1 is accepted, present TERM and go to TERM.
  - TERM: when TERM is accepted, go to DONE with tx_valid=0.
  - DONE (1 cycle): done[winner]=1, gnt=0, pointer=(winner+1) mod 4, then go to IDLE.
- Latency:
  - req rises while IDLE at edge N → gnt and first tx_valid after edge N+1.
  - With tx_ready tied high, a full transfer takes NBYTES+1 byte cycles + 1 DONE cycle + 1 IDLE cycle between back-to-back grants.
- Message latching: msgX is sampled only at the grant edge. Later changes to msgX do not affect the transfer in progress.
- req deasserted mid-transfer: the transfer still completes and done still pulses. The requester is expected to hold req; this is not an error.
- tx_ready low: output holds indefinitely with no timeout; state and index are frozen.
- Simultaneous requests: exactly one grant, chosen by the round-robin order.
- A requester still holding req after its done pulse becomes lowest priority.
- Only one done bit is ever high, and only in the DONE cycle.
- Index counter width is ceil(log2(NBYTES+1)); it never exceeds NBYTES-1 in SEND.

Optional Feature:
- Macro: DISP_MSG_SCHED_LF_EN.
- Defined: after TERM (8'h0d) is accepted, the block presents a line-feed byte 8'h0a (state LF) before DONE. Transfer length becomes NBYTES+2 bytes.
- Undefined: there is no LF state and the sequence ends after TERM. Port list is identical in both builds.

Test Plan:
- Reset then a single request: req=4'b0001, msg0="ABCDEFG" (byte0=8'h41), tx_ready=1 → gnt=0001 one cycle later; tx_data 41,42,43,44,45,46,47,0d on consecutive cycles; done=0001 for 1 cycle; gnt=0.
- Contention: req=4'b1010 held continuously → requester 1 served first, then 3, then 1 again. done pulses alternate 0010, 1000, 0010.
- Backpressure: tx_ready toggling 1,0,0,1,… during a transfer → every byte appears exactly once and in order; tx_data is stable during low-ready cycles.
- Message change: msg2 altered after gnt=0100 → transmitted bytes match the value at grant; req2 dropped mid-transfer → transfer finishes and done=0100 still pulses.
- Reset mid-transfer: assert rst after byte 3 → next cycle tx_valid=0, gnt=0, done=0, pointer=0. A subsequent req=4'b1111 grants requester 0.
- With DISP_MSG_SCHED_LF_EN defined: single request → 7 bytes, then 0d, then 0a, then done. Without the macro: no 0a byte.
